// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - int8 fully-connected layer with ReLU clamp and two-per-word result packing
module fc_layer_engine #(
  parameter int ADDR_W = 12,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              fc_run,
  output logic              fc_busy,
  output logic              fc_done,
  input  logic [ADDR_W-1:0] in_words,
  input  logic [ADDR_W-1:0] neurons,
  output logic [ADDR_W-1:0] feat_sram_read_address,
  input  logic [15:0]       feat_sram_read_data,
  output logic [ADDR_W-1:0] wgt_sram_read_address,
  input  logic [15:0]       wgt_sram_read_data,
  output logic              res_sram_write_enable,
  output logic [ADDR_W-1:0] res_sram_write_address,
  output logic [15:0]       res_sram_write_data
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, ACT, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [ADDR_W-1:0]        feat_addr_q, feat_addr_d;
  logic [ADDR_W-1:0]        wgt_addr_q, wgt_addr_d;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        waddr_q, waddr_d;
  logic [15:0]              wdata_q, wdata_d;
  logic [7:0]               pack_q, pack_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]        in_words_q, in_words_d;
  logic [ADDR_W-1:0]        neurons_q, neurons_d;
  logic [ADDR_W-1:0]        j_q, j_d;

  logic signed [7:0]        f_hi, f_lo, w_hi, w_lo;
  logic signed [15:0]       prod_hi, prod_lo;
  logic signed [ACC_W-1:0]  mac_sum;
  logic                     mac_en;
  logic                     last_neuron;
  logic [7:0]               res;

  // Read data lags the issued address by one cycle, so word k-1 is MACed while word k is issued.
  always_comb begin
    f_hi        = feat_sram_read_data[15:8];
    f_lo        = feat_sram_read_data[7:0];
    w_hi        = wgt_sram_read_data[15:8];
    w_lo        = wgt_sram_read_data[7:0];
    prod_hi     = 16'(f_hi) * 16'(w_hi);
    prod_lo     = 16'(f_lo) * 16'(w_lo);
    mac_sum     = acc_q + ACC_W'(prod_hi) + ACC_W'(prod_lo);
    mac_en      = ((state_q == FETCH) && (feat_addr_q != '0)) || (state_q == DRAIN);
    last_neuron = (j_q == neurons_q - ADDR_W'(1));
    if (acc_q[ACC_W-1]) begin
      res = 8'd0;
    end else if (acc_q > ACC_W'(127)) begin
      res = 8'd127;
    end else begin
      res = acc_q[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    feat_addr_d = feat_addr_q;
    wgt_addr_d  = wgt_addr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    pack_d      = pack_q;
    acc_d       = acc_q;
    in_words_d  = in_words_q;
    neurons_d   = neurons_q;
    j_d         = j_q;

    if (mac_en) begin
      acc_d = mac_sum;
    end

    case (state_q)
      IDLE: begin
        if (fc_run) begin
          in_words_d  = in_words;
          neurons_d   = neurons;
          feat_addr_d = '0;
          wgt_addr_d  = '0;
          j_d         = '0;
          acc_d       = '0;
          pack_d      = '0;
          busy_d      = 1'b1;
          state_d     = ((in_words == '0) || (neurons == '0)) ? DONE : FETCH;
        end
      end
      FETCH: begin
        // Weight address runs continuously across neurons: row j starts at j*in_words.
        wgt_addr_d = wgt_addr_q + ADDR_W'(1);
        if (feat_addr_q == in_words_q - ADDR_W'(1)) begin
          state_d = DRAIN;
        end else begin
          feat_addr_d = feat_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = ACT;
      end
      ACT: begin
        acc_d       = '0;
        j_d         = j_q + ADDR_W'(1);
        feat_addr_d = '0;
        if (!j_q[0]) begin
          pack_d = res;
        end
        if (j_q[0] || last_neuron) begin
          we_d    = 1'b1;
          waddr_d = j_q >> 1;
          wdata_d = j_q[0] ? {pack_q, res} : {res, 8'h00};
        end
        state_d = last_neuron ? DONE : FETCH;
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      feat_addr_q <= '0;
      wgt_addr_q  <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      pack_q      <= '0;
      acc_q       <= '0;
      in_words_q  <= '0;
      neurons_q   <= '0;
      j_q         <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      feat_addr_q <= feat_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      pack_q      <= pack_d;
      acc_q       <= acc_d;
      in_words_q  <= in_words_d;
      neurons_q   <= neurons_d;
      j_q         <= j_d;
    end
  end

  assign fc_busy                = busy_q;
  assign fc_done                = done_q;
  assign feat_sram_read_address = feat_addr_q;
  assign wgt_sram_read_address  = wgt_addr_q;
  assign res_sram_write_enable  = we_q;
  assign res_sram_write_address = waddr_q;
  assign res_sram_write_data    = wdata_q;

endmodule
